// File: rtl/mux2_sel_arbiter.sv
// mux2_sel_arbiter: round-robin select arbiter for a 2:1 mux; define MUX2_SEL_TIMEOUT_EN to force release after MAX_HOLD cycles under contention
module mux2_sel_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          done,
  output logic          S,
  output logic          gnt0,
  output logic          gnt1,
  output logic          busy,
  output logic [CW-1:0] hold_cnt
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;
`ifdef MUX2_SEL_TIMEOUT_EN
  localparam logic timeout_en = 1'b1;
`else
  localparam logic timeout_en = 1'b0;
`endif
  logic [0:0] state;
  logic ptr, pick, own_req, other_req, rel;
  always_comb begin
    pick = (req0 & req1) ? ~ptr : req1;
    own_req = S ? req1 : req0;
    other_req = S ? req0 : req1;
    rel = done | ~own_req | (timeout_en & other_req & (hold_cnt == CW'(MAX_HOLD - 1)));
  end
  assign busy = state == GRANT;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      S <= 1'b0;
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      hold_cnt <= '0;
      ptr <= 1'b1;
    end else if (state == IDLE) begin
      if (req0 | req1) begin
        state <= GRANT;
        S <= pick;
        gnt0 <= ~pick;
        gnt1 <= pick;
        hold_cnt <= '0;
        ptr <= pick;
      end
    end else if (rel) begin
      state <= IDLE;
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      hold_cnt <= '0;
    end else begin
      hold_cnt <= (hold_cnt == '1) ? hold_cnt : hold_cnt + 1'b1;
    end
  end
endmodule

// File: doc/mux2_sel_arbiter.md
Name: mux2_sel_arbiter

Overview:
- Two-requester round-robin arbiter that owns the select line of the team's 2:1 mux. It sits directly upstream of the mux and decides which of I0/I1 reaches Y.
- Each requester asserts a request, receives a registered grant, and holds the mux path until it signals done.
- Select changes only in IDLE. The mux output is therefore glitch-free with respect to a granted transfer.

Parameters:
- MAX_HOLD, 16, maximum grant length in cycles before forced release (used only when the optional feature is compiled in); legal range 2..255.
- CW, 8, width of the internal hold counter; must satisfy 2^CW > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req0  input  1  channel 0 (mux I0) requests the path.
- req1  input  1  channel 1 (mux I1) requests the path.
- done  input  1  current grantee releases the path (sampled only in GRANT).
- S  output  1  mux select: 0 = I0, 1 = I1; registered.
- gnt0  output  1  channel 0 owns the path; registered.
- gnt1  output  1  channel 1 owns the path; registered.
- busy  output  1  high while in GRANT; registered.
- hold_cnt  output  CW  cycles elapsed in the current grant; registered.

Behaviour:
- Reset (asynchronous, active-high): clk and rst are the only clock/reset. While rst=1 and on deassertion:
  - state=IDLE, S=0, gnt0=0, gnt1=0, busy=0, hold_cnt=0.
  - Internal last-grant pointer = 1, so channel 0 wins the first tie.
- States: IDLE and GRANT only.
- IDLE:
  - Grants are 0 and S holds its last value.
  - If exactly one request is high, grant that channel.
  - If both are high, grant the channel not equal to the last-grant pointer.
  - On the next edge: state=GRANT, the selected gntX=1, S=X, busy=1, hold_cnt=0, pointer=X.
  - Latency: a request first high in cycle n produces a grant visible after edge n+1.
- GRANT:
  - Grant, S and busy are held. hold_cnt increments each cycle and saturates at 2^CW-1.
  - Release when done=1, or when the granted channel's req=0.
  - On release, the next edge gives: state=IDLE, gnt0=gnt1=0, busy=0, hold_cnt=0; S is unchanged.
- Mandatory gap: at least one IDLE cycle separates consecutive grants, so S never changes while gnt is high.
- Mutual exclusion: gnt0 & gnt1 is never 1.
- Simultaneous events:
  - done in the same cycle as a new request from the other channel: release first; the new grant follows after the IDLE cycle.
  - done while in IDLE: ignored.
- Reset mid-grant: outputs clear immediately (asynchronous); the pointer returns to 1.
- Fairness: under continuous dual requests with done pulses, grants alternate 0,1,0,1...

Optional Feature:
- Macro: MUX2_SEL_TIMEOUT_EN.
- Defined:
  - In GRANT, if hold_cnt == MAX_HOLD-1 and the non-granted channel's request is high, force a release on the next edge exactly as for done.
  - The pointer then guarantees the waiting channel wins the following arbitration.
  - With no competing request, the grant may exceed MAX_HOLD.
- Not defined:
  - No forced release; a grant ends only on done or on req drop.
  - hold_cnt is still present and counting.

Test Plan:
- Reset then idle: rst=1 for 3 cycles, then rst=0 with req0=req1=0 for 10 cycles -> S=0, gnt0=gnt1=0, busy=0, hold_cnt=0 throughout.
- Single request: req1=1 at cycle 5 -> gnt1=1, S=1, busy=1 after edge 6. done=1 at cycle 10 -> gnt1=0, busy=0 after edge 11, and S stays 1.
- Tie and alternation: req0=req1=1 held, with a done pulse 4 cycles after each grant -> grant order 0,1,0,1. Check S equals the grantee, there is one IDLE cycle between grants, and gnt0 & gnt1 is never 1.
- Request drop: grant ch0, then deassert req0 at hold_cnt=3 -> gnt0=0 on the next edge, with no done needed.
- Reset mid-grant: gnt1=1 and hold_cnt=5, pulse rst asynchronously between edges -> all outputs 0 immediately. With both requests then high, ch0 is granted first.
- Timeout (macro defined, MAX_HOLD=16): ch0 granted, req0=req1=1, done=0 -> gnt0 drops after hold_cnt=15, then gnt1=1, S=1 one IDLE cycle later. With the macro undefined, gnt0 is still high at hold_cnt=40.
